// File: rtl/main_fifo.sv
// Single-clock FIFO with a registered read port, registered empty/full flags
// and exposed head/tail pointers. Pointers wrap explicitly, so any depth >= 2 works.
module main_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DATA_SIZE  = 8,
  localparam int PTR_W     = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_write,
  input  logic                  en_read,
  output logic                  empty,
  output logic                  full,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out,
  output logic [PTR_W-1:0]      head,
  output logic [PTR_W-1:0]      tail
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [DATA_SIZE];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, full_q;
  logic [DATA_WIDTH-1:0] out_q;

  logic wr_ok;
  logic rd_ok;

  // Acceptance uses the registered flags, so a read on an empty FIFO never
  // falls through to the word being written in the same cycle.
  assign wr_ok = en_write & ~full_q;
  assign rd_ok = en_read  & ~empty_q;

  always_comb begin
    head_d = head_q;
    if (rd_ok) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
    end
  end

  always_comb begin
    tail_d = tail_q;
    if (wr_ok) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[tail_q] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
      if (rd_ok) begin
        out_q <= mem_q[head_q];
      end
    end
  end

  assign empty = empty_q;
  assign full  = full_q;
  assign out   = out_q;
  assign head  = head_q;
  assign tail  = tail_q;

endmodule

// File: tb/tb_main_fifo.sv
// Directed bench for main_fifo: stimulus pushes expected post-edge state into a
// scoreboard queue that a separate monitor pops and compares after each edge.
module tb_main_fifo;

  logic       clk;
  logic       rst;
  logic       en_write;
  logic       en_read;
  logic       empty;
  logic       full;
  logic [3:0] in;
  logic [3:0] out;
  logic [2:0] head;
  logic [2:0] tail;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       e;
    logic       f;
    logic [2:0] h;
    logic [2:0] t;
    logic [3:0] o;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [3:0] mq[$];
  logic [2:0] m_head;
  logic [2:0] m_tail;
  logic [3:0] m_out;

  main_fifo #(.DATA_WIDTH(4), .DATA_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_write (en_write),
    .en_read  (en_read),
    .empty    (empty),
    .full     (full),
    .in       (in),
    .out      (out),
    .head     (head),
    .tail     (tail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_head = '0;
    m_tail = '0;
    m_out  = '0;
  endtask

  // One clock cycle of stimulus; expectation is queued before the edge.
  task automatic cyc(input logic we, input logic re, input logic [3:0] din);
    exp_t x;
    logic wr_ok, rd_ok;
    @(negedge clk);
    en_write = we;
    en_read  = re;
    in       = din;
    wr_ok = we && (mq.size() < 8);
    rd_ok = re && (mq.size() > 0);
    if (rd_ok) begin
      m_out  = mq.pop_front();
      m_head = m_head + 3'd1;
    end
    if (wr_ok) begin
      mq.push_back(din);
      m_tail = m_tail + 3'd1;
    end
    x.e = (mq.size() == 0);
    x.f = (mq.size() == 8);
    x.h = m_head;
    x.t = m_tail;
    x.o = m_out;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
    en_write = 1'b0;
    en_read  = 1'b0;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        $display("txn t=%0t empty=%0b full=%0b head=%0d tail=%0d out=%0h", $time, empty, full, head, tail, out);
        chk("sb_empty", 32'(empty), 32'(x.e));
        chk("sb_full",  32'(full),  32'(x.f));
        chk("sb_head",  32'(head),  32'(x.h));
        chk("sb_tail",  32'(tail),  32'(x.t));
        chk("sb_out",   32'(out),   32'(x.o));
      end
    end
  end

  initial begin
    rst      = 1'b0;
    en_write = 1'b0;
    en_read  = 1'b0;
    in       = '0;
    model_reset();

    // reset held while requests toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en_write = i[0];
      en_read  = i[1];
      in       = 4'(i + 3);
      @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_head",  32'(head),  32'd0);
      chk("rst_tail",  32'(tail),  32'd0);
      chk("rst_out",   32'(out),   32'd0);
    end
    @(negedge clk);
    en_write = 1'b0;
    en_read  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_tail",  32'(tail),  32'd0);

    // fill 1..8 then drain in order
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 4'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_tail", 32'(tail), 32'd0);
    cyc(1'b1, 1'b0, 4'hF);
    chk("ovf_tail", 32'(tail), 32'd0);
    chk("ovf_full", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 4'h0);
      chk("drain_out", 32'(out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_head",  32'(head),  32'd0);
    cyc(1'b0, 1'b1, 4'h0);
    chk("unf_out",  32'(out),  32'd8);
    chk("unf_head", 32'(head), 32'd0);

    // simultaneous read/write with A,B,C stored
    cyc(1'b1, 1'b0, 4'hA);
    cyc(1'b1, 1'b0, 4'hB);
    cyc(1'b1, 1'b0, 4'hC);
    cyc(1'b1, 1'b1, 4'hD);
    chk("both_out",  32'(out),  32'hA);
    chk("both_head", 32'(head), 32'd1);
    chk("both_tail", 32'(tail), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 4'h0);
      chk("both_seq", 32'(out), 32'(4'hB + i));
    end
    cyc(1'b1, 1'b1, 4'h5);
    chk("both_empty_flag", 32'(empty), 32'd0);
    chk("both_empty_out",  32'(out),   32'hD);
    chk("both_empty_tail", 32'(tail),  32'd5);
    cyc(1'b0, 1'b1, 4'h0);
    chk("both_empty_rd", 32'(out), 32'h5);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 4'(i));
    chk("refill_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 4'hF);
    chk("both_full_flag", 32'(full), 32'd0);
    chk("both_full_out",  32'(out),  32'd1);
    chk("both_full_tail", 32'(tail), 32'd5);
    for (int i = 2; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 4'h0);
      chk("full_drain_out", 32'(out), 32'(i));
    end
    chk("full_drain_empty", 32'(empty), 32'd1);

    // wrap-around: alternating write/read
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) cyc(1'b1, 1'b0, 4'(i / 2 + 1));
      else begin
        cyc(1'b0, 1'b1, 4'h0);
        chk("wrap_out", 32'(out), 32'(i / 2 + 1));
      end
    end

    // asynchronous reset between edges
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'(i + 2));
    cyc(1'b0, 1'b1, 4'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full),  32'd0);
    chk("arst_head",  32'(head),  32'd0);
    chk("arst_tail",  32'(tail),  32'd0);
    chk("arst_out",   32'(out),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 4'h9);
    cyc(1'b0, 1'b1, 4'h0);
    chk("arst_after_out", 32'(out), 32'h9);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
